// File: rtl/fft_col_collector.sv
// fft_col_collector: write-back side of one FFT butterfly column.
// Drives the shared MAC phase select, scatters the two results of every lane
// into a 32-slot frame register on each accepted beat, and presents the
// completed column (four phases) downstream with a valid/ready handshake.
// Optional build macro FFT_COL_BITREV_EN: slot s lands at outmac position
// bitrev(s), giving natural-order FFT output. Undefined: identity placement.
module fft_col_collector #(
   parameter int LANES  = 4,
   parameter int PHASES = 4,
   parameter int WORD_W = 64
) (
   input  logic                             clk,
   input  logic                             reset,
   output logic [1:0]                       mac_sel,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [2*LANES*WORD_W-1:0]        macout,
   output logic                             frame_valid,
   input  logic                             frame_ready,
   output logic [LANES*PHASES*2*WORD_W-1:0] outmac,
   output logic [7:0]                       frame_cnt
);

   localparam int SLOTS = LANES * PHASES * 2;

   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] FULL    = 1'b1;

`ifdef FFT_COL_BITREV_EN
   localparam int SLOT_AW = $clog2(SLOTS);

   // Output position of slot s: bit-reversed index for natural-order output.
   function automatic int unsigned slot_pos(input int unsigned s);
      int unsigned r;
      r = 0;
      for (int i = 0; i < SLOT_AW; i++) begin
         r[SLOT_AW-1-i] = s[i];
      end
      return r;
   endfunction
`else
   // Output position of slot s: identity placement.
   function automatic int unsigned slot_pos(input int unsigned s);
      return s;
   endfunction
`endif

   logic [0:0] state;
   logic       accept;
   logic       drain;
   logic       last_beat;

   assign frame_valid = (state == FULL);
   // Ready whenever nothing is held or the held frame leaves this cycle,
   // so a new frame's first beat can overlap the previous frame's drain.
   assign in_ready    = !frame_valid || frame_ready;
   assign accept      = in_valid && in_ready;
   assign drain       = frame_valid && frame_ready;
   assign last_beat   = (mac_sel == 2'(PHASES - 1));

   // Control: phase select, frame state and drained-frame counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= COLLECT;
         mac_sel   <= 2'd0;
         frame_cnt <= 8'd0;
      end else begin
         if (accept) begin
            mac_sel <= mac_sel + 2'd1;
         end
         if (drain) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
         case (state)
            COLLECT: if (accept && last_beat) state <= FULL;
            FULL:    if (drain)               state <= COLLECT;
            default:                          state <= COLLECT;
         endcase
      end
   end

   // Frame register: each accepted beat scatters lane l, output k of phase p
   // into slot 8l+4k+p; untouched slots keep their previous-frame contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         outmac <= '0;
      end else if (accept) begin
         for (int s = 0; s < SLOTS; s++) begin
            if (mac_sel == 2'(s % PHASES)) begin
               outmac[WORD_W*slot_pos(s) +: WORD_W] <=
                  macout[(2*(s/(2*PHASES)) + ((s/PHASES) % 2))*WORD_W +: WORD_W];
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_col_collector.sv
// Bench for fft_col_collector: directed beats with tagged words, a frame-level
// reference model checked every cycle, plus hand-computed literal checks.
// Honours FFT_COL_BITREV_EN to place slots the same way the build does.
module tb_fft_col_collector;

   logic           clk;
   logic           reset;
   logic [1:0]     mac_sel;
   logic           in_valid;
   logic           in_ready;
   logic [511:0]   macout;
   logic           frame_valid;
   logic           frame_ready;
   logic [2047:0]  outmac;
   logic [7:0]     frame_cnt;

   int total = 0;
   int bad   = 0;

   // reference model state: beats accepted since reset, frames drained, slot image
   int          m_tot = 0;
   int          m_drained = 0;
   logic [63:0] m_out [32];
   bit          mv = 0;

   fft_col_collector dut (
      .clk         (clk),
      .reset       (reset),
      .mac_sel     (mac_sel),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .macout      (macout),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .outmac      (outmac),
      .frame_cnt   (frame_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int mpos(input int s);
      logic [4:0] v;
      v = 5'(s);
`ifdef FFT_COL_BITREV_EN
      return int'({v[0], v[1], v[2], v[3], v[4]});
`else
      return int'(v);
`endif
   endfunction

   function automatic logic [511:0] mk(input int fid, input int ph);
      logic [511:0] r;
      r = '0;
      for (int l = 0; l < 4; l++)
         for (int k = 0; k < 2; k++)
            r[(2*l+k)*64 +: 64] = 64'hA000_0000_0000_0000 | (64'(fid & 255) << 16)
                                  | (64'(l) << 8) | (64'(k) << 4) | 64'(ph);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Compare DUT against the model on the falling edge, then advance the model
   // by what the coming rising edge must do.
   always @(negedge clk) begin
      logic m_fv, exp_rdy, acc, drn;
      int   ph;
      m_fv    = (m_tot / 4) > m_drained;
      exp_rdy = !m_fv || frame_ready;
      if (mv) begin
         chk("mac_sel", 64'(mac_sel), 64'(m_tot % 4));
         chk("frame_valid", 64'(frame_valid), 64'(m_fv));
         chk("in_ready", 64'(in_ready), 64'(exp_rdy));
         chk("frame_cnt", 64'(frame_cnt), 64'(m_drained % 256));
         for (int i = 0; i < 32; i++)
            chk($sformatf("outmac[%0d]", i), outmac[64*i +: 64], m_out[i]);
      end
      if (reset) begin
         m_tot = 0;
         m_drained = 0;
         for (int i = 0; i < 32; i++) m_out[i] = 64'd0;
         mv = 1;
      end else if (mv) begin
         acc = in_valid && exp_rdy;
         drn = m_fv && frame_ready;
         if (acc) begin
            ph = m_tot % 4;
            for (int l = 0; l < 4; l++)
               for (int k = 0; k < 2; k++)
                  m_out[mpos(8*l + 4*k + ph)] = macout[(2*l+k)*64 +: 64];
            m_tot++;
         end
         if (drn) m_drained++;
      end
   end

   task automatic step(input logic v, input logic fr, input int fid);
      in_valid    = v;
      frame_ready = fr;
      macout      = mk(fid, m_tot % 4);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      frame_ready = 1'b0;
      macout = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset mac_sel", 64'(mac_sel), 64'd0);
      chk("reset frame_valid", 64'(frame_valid), 64'd0);
      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk("reset outmac slot5", outmac[5*64 +: 64], 64'd0);

      // back-to-back frame with downstream ready
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 0);
      chk("t1 fv before last", 64'(frame_valid), 64'd0);
      chk("t1 mac_sel before last", 64'(mac_sel), 64'd3);
      step(1'b1, 1'b1, 0);
      chk("t1 fv after last", 64'(frame_valid), 64'd1);
      chk("t1 mac_sel wrap", 64'(mac_sel), 64'd0);
`ifdef FFT_COL_BITREV_EN
      chk("t1 slot23 at 29", outmac[29*64 +: 64], 64'hA000_0000_0000_0213);
`else
      chk("t1 slot23", outmac[23*64 +: 64], 64'hA000_0000_0000_0213);
`endif
      chk("t1 slot0", outmac[0 +: 64], 64'hA000_0000_0000_0000);
      step(1'b0, 1'b1, 0);
      chk("t1 frame_cnt", 64'(frame_cnt), 64'd1);
      chk("t1 fv drained", 64'(frame_valid), 64'd0);

      // backpressure, then drain coincident with next frame's first beat
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2);
      chk("t2 in_ready held", 64'(in_ready), 64'd0);
      chk("t2 mac_sel frozen", 64'(mac_sel), 64'd0);
      chk("t2 fv held", 64'(frame_valid), 64'd1);
      step(1'b1, 1'b1, 2);
      chk("t3 frame_cnt", 64'(frame_cnt), 64'd2);
      chk("t3 mac_sel", 64'(mac_sel), 64'd1);
      chk("t3 fv", 64'(frame_valid), 64'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2);
      chk("t3 second frame fv", 64'(frame_valid), 64'd1);
      step(1'b0, 1'b1, 2);
      chk("t3 frame_cnt 3", 64'(frame_cnt), 64'd3);

      // in_valid toggling
      for (int i = 0; i < 6; i++) step(1'((i % 2) == 0), 1'b1, 3);
      chk("t4 fv after 6", 64'(frame_valid), 64'd0);
      chk("t4 mac_sel after 6", 64'(mac_sel), 64'd3);
      step(1'b1, 1'b1, 3);
      chk("t4 fv after 7", 64'(frame_valid), 64'd1);
      step(1'b0, 1'b1, 3);

      // reset mid-frame
      step(1'b1, 1'b1, 4);
      step(1'b1, 1'b1, 4);
      reset = 1'b1;
      step(1'b0, 1'b0, 4);
      reset = 1'b0;
      chk("t5 mac_sel", 64'(mac_sel), 64'd0);
      chk("t5 fv", 64'(frame_valid), 64'd0);
      chk("t5 frame_cnt", 64'(frame_cnt), 64'd0);
      chk("t5 outmac slot0", outmac[0 +: 64], 64'd0);
      chk("t5 outmac slot9", outmac[9*64 +: 64], 64'd0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 5);
      chk("t5 clean frame fv", 64'(frame_valid), 64'd1);
      step(1'b0, 1'b1, 5);
      chk("t5 frame_cnt", 64'(frame_cnt), 64'd1);

      // placement of lane1 k0 p1 (slot 9)
      for (int ph = 0; ph < 4; ph++) begin
         in_valid = 1'b1;
         frame_ready = 1'b1;
         macout = mk(7, ph);
         if (ph == 1) macout[2*64 +: 64] = 64'h3F80_0000_0000_0000;
         @(posedge clk);
         #1;
      end
`ifdef FFT_COL_BITREV_EN
      chk("t6 slot9 at 18", outmac[18*64 +: 64], 64'h3F80_0000_0000_0000);
`else
      chk("t6 slot9", outmac[9*64 +: 64], 64'h3F80_0000_0000_0000);
`endif
      step(1'b0, 1'b1, 7);

      // frame counter wrap
      reset = 1'b1;
      step(1'b0, 1'b0, 0);
      reset = 1'b0;
      for (int i = 0; i < 1020; i++) step(1'b1, 1'b1, i / 4);
      chk("t7 fv", 64'(frame_valid), 64'd1);
      chk("t7 frame_cnt 254", 64'(frame_cnt), 64'd254);
      step(1'b0, 1'b1, 0);
      chk("t7 frame_cnt 255", 64'(frame_cnt), 64'd255);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 9);
      step(1'b0, 1'b1, 9);
      chk("t7 frame_cnt wrap", 64'(frame_cnt), 64'd0);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
